// File: rtl/lookup_engine_pipe.sv
// Pipelined ternary lookup: parallel TCAM compare, lowest-index priority encode,
// registered action-table read. key_valid sampled at edge t yields action_valid at edge t+3.
module lookup_engine_pipe #(
    parameter int STAGE = 0,
    parameter int PHV_LEN = 1124,
    parameter int KEY_LEN = 197,
    parameter int ACT_LEN = 25,
    parameter int ACT_NUM = 25,
    parameter int DEPTH = 16,
    parameter logic [ACT_LEN*ACT_NUM-1:0] DEFAULT_ACT = 'h3f,
    localparam int ACT_W = ACT_LEN*ACT_NUM,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_LEN-1:0] extract_key,
    input  logic               key_valid,
    input  logic [PHV_LEN-1:0] phv_in,
    output logic [ACT_W-1:0]   action,
    output logic               action_valid,
    output logic               action_hit,
    output logic [PHV_LEN-1:0] phv_out,
    input  logic [KEY_LEN-1:0] lookup_din,
    input  logic [KEY_LEN-1:0] lookup_din_mask,
    input  logic [ADDR_W-1:0]  lookup_din_addr,
    input  logic               lookup_din_vld,
    input  logic               lookup_din_en,
    input  logic [ACT_W-1:0]   action_data_in,
    input  logic [ADDR_W-1:0]  action_addr,
    input  logic               action_en,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);

    if (STAGE < 0 || DEPTH < 2 || DEPTH > 64) begin : g_bad_param
        $error("lookup_engine_pipe stage %0d: DEPTH %0d outside 2..64", STAGE, DEPTH);
    end

    logic [KEY_LEN-1:0] ent_key_q  [DEPTH];
    logic [KEY_LEN-1:0] ent_mask_q [DEPTH];
    logic [DEPTH-1:0]   ent_vld_q;
    logic [ACT_W-1:0]   act_mem_q  [DEPTH];

    logic [DEPTH-1:0]   hit_d;
    logic               s1_vld_q;
    logic [DEPTH-1:0]   s1_hit_q;
    logic [PHV_LEN-1:0] s1_phv_q;

    logic [ADDR_W-1:0]  s2_addr_d;
    logic               s2_any_d;
    logic               s2_vld_q;
    logic [ADDR_W-1:0]  s2_addr_q;
    logic               s2_any_q;
    logic [PHV_LEN-1:0] s2_phv_q;

    logic               s3_vld_q;
    logic [ACT_W-1:0]   s3_act_q;
    logic               s3_hit_q;
    logic [PHV_LEN-1:0] s3_phv_q;

    logic               out_vld_q;
    logic [ACT_W-1:0]   out_act_q;
    logic               out_hit_q;
    logic [PHV_LEN-1:0] out_phv_q;
    logic [31:0]        hit_cnt_q;
    logic [31:0]        miss_cnt_q;

    // Index decode against every entry: an out-of-range index selects nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_key_q[i]  <= '0;
                ent_mask_q[i] <= '0;
            end
            ent_vld_q <= '0;
        end else if (lookup_din_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lookup_din_addr == ADDR_W'(i)) begin
                    ent_key_q[i]  <= lookup_din;
                    ent_mask_q[i] <= lookup_din_mask;
                    ent_vld_q[i]  <= lookup_din_vld;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                act_mem_q[i] <= '0;
            end
        end else if (action_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (action_addr == ADDR_W'(i)) begin
                    act_mem_q[i] <= action_data_in;
                end
            end
        end
    end

    // Compare the raw input key so a same-edge TCAM write is not yet visible.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_d[i] = ent_vld_q[i] & ~|((extract_key ^ ent_key_q[i]) & ~ent_mask_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_hit_q <= '0;
            s1_phv_q <= '0;
        end else begin
            s1_vld_q <= key_valid;
            if (key_valid) begin
                s1_hit_q <= hit_d;
                s1_phv_q <= phv_in;
            end
        end
    end

    always_comb begin
        s2_addr_d = '0;
        s2_any_d  = |s1_hit_q;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                s2_addr_d = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_any_q  <= 1'b0;
            s2_phv_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_addr_q <= s2_addr_d;
                s2_any_q  <= s2_any_d;
                s2_phv_q  <= s1_phv_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld_q <= 1'b0;
            s3_act_q <= '0;
            s3_hit_q <= 1'b0;
            s3_phv_q <= '0;
        end else begin
            s3_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                s3_act_q <= act_mem_q[s2_addr_q];
                s3_hit_q <= s2_any_q;
                s3_phv_q <= s2_phv_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_act_q  <= '0;
            out_hit_q  <= 1'b0;
            out_phv_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            out_vld_q <= s3_vld_q;
            if (s3_vld_q) begin
                out_act_q <= s3_hit_q ? s3_act_q : DEFAULT_ACT;
                out_hit_q <= s3_hit_q;
                out_phv_q <= s3_phv_q;
                if (s3_hit_q && hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
                if (!s3_hit_q && miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign action       = out_act_q;
    assign action_valid = out_vld_q;
    assign action_hit   = out_hit_q;
    assign phv_out      = out_phv_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule
